// File: rtl/pipe_hold_ctrl_pkg.sv
// pipe_hold_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller: FSM state
// encodings, hold/flush bit indices and the canned hold/flush masks used by
// the output decode.
`ifndef HOLD_ENA
`define HOLD_ENA 3:0
`endif

package pipe_hold_ctrl_pkg;

    // Controller states; the encoding is visible on state_o for trace.
    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_LOAD_BUBBLE = 2'd1,
        ST_DIV_WAIT    = 2'd2,
        ST_BUS_WAIT    = 2'd3
    } state_t;

    // Bit positions inside hold_o.
    localparam int HOLD_PC     = 0;
    localparam int HOLD_IF_ID  = 1;
    localparam int HOLD_ID_EX  = 2;
    localparam int HOLD_EX_MEM = 3;

    // Bit positions inside flush_o.
    localparam int FLUSH_IF_ID = 0;
    localparam int FLUSH_ID_EX = 1;

    // Hold masks: front end only (load-use), everything up to EX (divide),
    // and the whole pipe (bus wait).
    localparam logic [`HOLD_ENA] HOLD_NONE  = 4'b0000;
    localparam logic [`HOLD_ENA] HOLD_FRONT = (4'b0001 << HOLD_PC) | (4'b0001 << HOLD_IF_ID);
    localparam logic [`HOLD_ENA] HOLD_DIV   = HOLD_FRONT | (4'b0001 << HOLD_ID_EX);
    localparam logic [`HOLD_ENA] HOLD_ALL   = HOLD_DIV | (4'b0001 << HOLD_EX_MEM);

    // Flush masks: bubble into ID/EX only, or kill both younger stages.
    localparam logic [1:0] FLUSH_NONE   = 2'b00;
    localparam logic [1:0] FLUSH_BUBBLE = 2'b01 << FLUSH_ID_EX;
    localparam logic [1:0] FLUSH_BOTH   = (2'b01 << FLUSH_IF_ID) | (2'b01 << FLUSH_ID_EX);

endpackage

// File: rtl/pipe_hold_ctrl_wdog.sv
// pipe_hold_ctrl_wdog
// Watchdog counter for the wait states: clears on request, otherwise counts
// up while enabled and saturates at all-ones. at_limit flags cnt == limit.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   clr      - load zero this edge (wait-state entry); wins over inc
//   inc      - count this edge
//   limit    - compare value (timeout - 1)
//   at_limit - combinational compare of the registered count with limit
module pipe_hold_ctrl_wdog #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt_r;

    // Loadable saturating up-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == limit);

endmodule

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl
// Central stall/flush controller for the 5-stage pipeline. Arbitrates jump,
// divide, bus-wait and load-use requests into per-stage hold bits, flush
// strobes and a PC redirect. Wait states are guarded by a watchdog that
// forces a return to RUN and pulses timeout_o.
// Ports:
//   clk_100MHz   - clock, rising edge
//   arst         - asynchronous active-high reset
//   jump_req_i   - taken branch/jump resolved in EX
//   jump_addr_i  - jump target
//   load_use_i   - ID depends on the load currently in EX
//   div_start_i  - EX issues a multi-cycle divide
//   div_done_i   - divider result valid
//   bus_hold_i   - memory bus not ready
//   hold_o       - [0] pc, [1] if_id, [2] id_ex, [3] ex_mem (1 = keep)
//   flush_o      - [0] if_id, [1] id_ex (1 = load NOP)
//   jump_o       - PC must load jump_addr_o
//   jump_addr_o  - redirect target, zero when jump_o is low
//   timeout_o    - one-cycle watchdog expiry pulse (registered)
//   state_o      - current FSM state (registered)
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 34,
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    input  logic              jump_req_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              load_use_i,
    input  logic              div_start_i,
    input  logic              div_done_i,
    input  logic              bus_hold_i,
    output logic [`HOLD_ENA]  hold_o,
    output logic [1:0]        flush_o,
    output logic              jump_o,
    output logic [31:0]       jump_addr_o,
    output logic              timeout_o,
    output logic [1:0]        state_o
);

    localparam logic [CNT_W-1:0] DIV_LIMIT = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BUS_LIMIT = CNT_W'(BUS_TIMEOUT - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic              timeout_r;
    logic              expire_s;
    logic              enter_wait_s;
    logic              in_wait_s;
    logic              at_limit_s;
    logic [CNT_W-1:0]  limit_s;
    logic [`HOLD_ENA]  hold_s;
    logic [1:0]        flush_s;
    logic              jump_s;
    logic [31:0]       jump_addr_s;

    assign in_wait_s = (state_r == ST_DIV_WAIT) || (state_r == ST_BUS_WAIT);
    assign limit_s   = (state_r == ST_BUS_WAIT) ? BUS_LIMIT : DIV_LIMIT;

    pipe_hold_ctrl_wdog #(
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk      (clk_100MHz),
        .rst      (arst),
        .clr      (enter_wait_s),
        .inc      (in_wait_s),
        .limit    (limit_s),
        .at_limit (at_limit_s)
    );

    // Next-state and Mealy output decode.
    always_comb begin
        next_state_s = state_r;
        hold_s       = HOLD_NONE;
        flush_s      = FLUSH_NONE;
        jump_s       = 1'b0;
        jump_addr_s  = 32'h0000_0000;
        expire_s     = 1'b0;
        enter_wait_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (jump_req_i) begin
                    jump_s      = 1'b1;
                    jump_addr_s = jump_addr_i;
                    flush_s     = FLUSH_BOTH;
                end else if (div_start_i && !div_done_i) begin
                    hold_s       = HOLD_DIV;
                    next_state_s = ST_DIV_WAIT;
                    enter_wait_s = 1'b1;
                end else if (bus_hold_i) begin
                    // A single-cycle divide (start with done) needs nothing,
                    // so a concurrent bus wait is still honoured.
                    hold_s       = HOLD_ALL;
                    next_state_s = ST_BUS_WAIT;
                    enter_wait_s = 1'b1;
                end else if (load_use_i) begin
                    hold_s       = HOLD_FRONT;
                    flush_s      = FLUSH_BUBBLE;
                    next_state_s = ST_LOAD_BUBBLE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_LOAD_BUBBLE: begin
                // load_use_i is ignored so the bubble is exactly one cycle.
                if (bus_hold_i) begin
                    hold_s       = HOLD_ALL;
                    next_state_s = ST_BUS_WAIT;
                    enter_wait_s = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DIV_WAIT: begin
                if (div_done_i) begin
                    next_state_s = ST_RUN;
                end else begin
                    // Hold stays asserted even on the expiry cycle.
                    hold_s = HOLD_DIV;
                    if (at_limit_s) begin
                        next_state_s = ST_RUN;
                        expire_s     = 1'b1;
                    end else begin
                        next_state_s = ST_DIV_WAIT;
                    end
                end
            end
            ST_BUS_WAIT: begin
                if (!bus_hold_i) begin
                    next_state_s = ST_RUN;
                end else begin
                    hold_s = HOLD_ALL;
                    if (at_limit_s) begin
                        next_state_s = ST_RUN;
                        expire_s     = 1'b1;
                    end else begin
                        next_state_s = ST_BUS_WAIT;
                    end
                end
            end
            default: begin
                next_state_s = ST_RUN;
            end
        endcase
    end

    // State register and registered watchdog pulse.
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            state_r   <= ST_RUN;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            timeout_r <= expire_s;
        end
    end

    assign hold_o      = hold_s;
    assign flush_o     = flush_s;
    assign jump_o      = jump_s;
    assign jump_addr_o = jump_addr_s;
    assign timeout_o   = timeout_r;
    assign state_o     = state_r;

endmodule
